// File: rtl/smart_toilet_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : smart_toilet_seq_pkg
// Brief   : Phase encodings and per-phase valve masks for the assay sequencer.
// Revision: 1.0  initial release
// ============================================================================
package smart_toilet_seq_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_PRIME = 3'd1,
        PH_MIX0  = 3'd2,
        PH_LOAD3 = 3'd3,
        PH_MIX1  = 3'd4,
        PH_DISP  = 3'd5,
        PH_FLUSH = 3'd6
    } phase_t;

    // Mask bit order: {soln1, soln2, soln3, out, waste}
    localparam logic [4:0] MASK_IDLE  = 5'b00000;
    localparam logic [4:0] MASK_PRIME = 5'b01001;
    localparam logic [4:0] MASK_MIX0  = 5'b11001;
    localparam logic [4:0] MASK_LOAD3 = 5'b00101;
    localparam logic [4:0] MASK_MIX1  = 5'b11101;
    localparam logic [4:0] MASK_DISP  = 5'b11110;
    localparam logic [4:0] MASK_FLUSH = 5'b01001;
    localparam logic [4:0] HOLD_MASK  = 5'b00001;

    function automatic logic [4:0] phase_mask(input phase_t p);
        case (p)
            PH_PRIME: phase_mask = MASK_PRIME;
            PH_MIX0:  phase_mask = MASK_MIX0;
            PH_LOAD3: phase_mask = MASK_LOAD3;
            PH_MIX1:  phase_mask = MASK_MIX1;
            PH_DISP:  phase_mask = MASK_DISP;
            PH_FLUSH: phase_mask = MASK_FLUSH;
            default:  phase_mask = MASK_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/smart_toilet_seq_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : phase_timer
// Brief   : Loadable down-counter timing the dwell of each sequencer phase.
// Revision: 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/smart_toilet_seq.sv
`default_nettype none
// ============================================================================
// Module  : smart_toilet_seq
// Brief   : Timed valve/pump sequencer: prime, mix0, load3, mix1, dispense, flush.
// Revision: 1.0  initial release
// ============================================================================
module smart_toilet_seq
    import smart_toilet_seq_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int T_PRIME = 400,
    parameter int T_MIX0  = 200,
    parameter int T_LOAD3 = 900,
    parameter int T_MIX1  = 300,
    parameter int T_DISP  = 150,
    parameter int T_FLUSH = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    output logic       valve_soln1,
    output logic       valve_soln2,
    output logic       valve_soln3,
    output logic       valve_out,
    output logic       valve_waste,
    output logic       pump_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] phase,
    output logic [7:0] run_count
);

    localparam longint MAXV = (64'd1 << CNT_W) - 64'd1;

    if (T_PRIME < 1 || T_PRIME > MAXV || T_MIX0 < 1 || T_MIX0 > MAXV ||
        T_LOAD3 < 1 || T_LOAD3 > MAXV || T_MIX1 < 1 || T_MIX1 > MAXV ||
        T_DISP  < 1 || T_DISP  > MAXV || T_FLUSH < 1 || T_FLUSH > MAXV) begin : g_param_check
        $error("smart_toilet_seq: every T_* must lie in 1..2^CNT_W-1");
    end

    function automatic logic [CNT_W-1:0] reload(input phase_t p);
        case (p)
            PH_PRIME: reload = CNT_W'(T_PRIME - 1);
            PH_MIX0:  reload = CNT_W'(T_MIX0 - 1);
            PH_LOAD3: reload = CNT_W'(T_LOAD3 - 1);
            PH_MIX1:  reload = CNT_W'(T_MIX1 - 1);
            PH_DISP:  reload = CNT_W'(T_DISP - 1);
            PH_FLUSH: reload = CNT_W'(T_FLUSH - 1);
            default:  reload = '0;
        endcase
    endfunction

    phase_t           state;
    phase_t           nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_zero;
    logic             abort_take;
    logic             hold_take;
    logic             accept;
    logic             fin;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    // Priority inside a run: abort, then hold, then timer expiry.
    always_comb begin
        nxt        = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;
        abort_take = 1'b0;
        hold_take  = 1'b0;
        case (state)
            PH_IDLE: begin
                if (start && !abort) begin
                    nxt      = PH_PRIME;
                    tmr_load = 1'b1;
                    tmr_val  = reload(PH_PRIME);
                end
            end
            PH_PRIME, PH_MIX0, PH_LOAD3, PH_MIX1, PH_DISP: begin
                if (abort) begin
                    abort_take = 1'b1;
                    nxt        = PH_FLUSH;
                    tmr_load   = 1'b1;
                    tmr_val    = reload(PH_FLUSH);
                end else if (hold) begin
                    hold_take = 1'b1;
                end else if (tmr_zero) begin
                    nxt      = phase_t'(state + 3'd1);
                    tmr_load = 1'b1;
                    tmr_val  = reload(nxt);
                end else begin
                    tmr_en = (tmr_cnt != '0);
                end
            end
            PH_FLUSH: begin
                if (hold) begin
                    hold_take = 1'b1;
                end else if (tmr_zero) begin
                    nxt = PH_IDLE;
                end else begin
                    tmr_en = (tmr_cnt != '0);
                end
            end
            default: nxt = PH_IDLE;
        endcase
    end

    assign accept = (state == PH_IDLE) && (nxt == PH_PRIME);
    assign fin    = (state == PH_FLUSH) && (nxt == PH_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PH_IDLE;
            {valve_soln1, valve_soln2, valve_soln3, valve_out, valve_waste} <= MASK_IDLE;
            pump_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            run_count <= 8'd0;
        end else begin
            state <= nxt;
            {valve_soln1, valve_soln2, valve_soln3, valve_out, valve_waste} <=
                hold_take ? HOLD_MASK : phase_mask(nxt);
            pump_en <= (nxt != PH_IDLE) && !hold_take;
            busy    <= (nxt != PH_IDLE);
            done    <= fin;
            if (abort_take) begin
                err <= 1'b1;
            end else if (accept) begin
                err <= 1'b0;
            end
            // err still flags an aborted run when its flush completes.
            if (fin && !err) begin
                run_count <= run_count + 8'd1;
            end
        end
    end

    assign phase = state;

endmodule
`default_nettype wire
